// File: rtl/spk_layer_engine.sv
// spk_layer_engine: threshold/refractory spike processor with a double-buffered,
// chunk-loaded input spike register. Optional per-neuron spike history: SPK_HIST_EN.
module spk_layer_engine #(
  parameter int N_NEURONS = 16,
  parameter int POT_W     = 8,
  parameter int REFRAC_W  = 3,
  parameter int IN_SPK_W  = 1024,
  parameter int CHUNK_W   = 128,
  parameter int HIST_W    = 8,
  localparam int NCHUNK   = IN_SPK_W / CHUNK_W,
  localparam int IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
  localparam int SEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int CNT_W    = $clog2(N_NEURONS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [POT_W-1:0]     cfg_threshold,
  input  logic [REFRAC_W-1:0]         cfg_refrac,
  input  logic                        step,
  input  logic [N_NEURONS*POT_W-1:0]  potential_in,
  output logic [N_NEURONS-1:0]        spk_out,
  output logic                        spk_valid,
  output logic [CNT_W-1:0]            spk_cnt,
  output logic [N_NEURONS-1:0]        refrac_active,
  input  logic [CHUNK_W-1:0]          in_chunk_data,
  input  logic [IDX_W-1:0]            in_chunk_idx,
  input  logic                        in_chunk_we,
  input  logic                        in_commit,
  output logic [IN_SPK_W-1:0]         in_spk_out,
  output logic [NCHUNK-1:0]           in_loaded,
  input  logic [SEL_W-1:0]            hist_sel,
  input  logic                        hist_clr,
  output logic [HIST_W-1:0]           hist_data
);

  logic [REFRAC_W-1:0] rc_r [N_NEURONS];
  logic [N_NEURONS-1:0] fire_s;
  logic [CNT_W-1:0]     fire_cnt_s;
  logic [IN_SPK_W-1:0]  shadow_r;
  logic [IN_SPK_W-1:0]  shadow_next_s;
  logic [NCHUNK-1:0]    chunk_hit_s;

  // Firing decision and spike count for the potentials presented this cycle
  always_comb begin
    fire_s     = '0;
    fire_cnt_s = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      fire_s[i]  = (rc_r[i] == '0) &&
                   ($signed(potential_in[i*POT_W +: POT_W]) >= cfg_threshold);
      fire_cnt_s = fire_cnt_s + CNT_W'(fire_s[i]);
    end
  end

  // Spike outputs and refractory counters advance only on a step
  always_ff @(posedge clk) begin
    if (reset) begin
      spk_out   <= '0;
      spk_valid <= 1'b0;
      spk_cnt   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        rc_r[i] <= '0;
      end
    end else begin
      spk_valid <= step;
      if (step) begin
        spk_out <= fire_s;
        spk_cnt <= fire_cnt_s;
        for (int i = 0; i < N_NEURONS; i++) begin
          if (fire_s[i]) begin
            rc_r[i] <= cfg_refrac;
          end else if (rc_r[i] != '0) begin
            rc_r[i] <= rc_r[i] - REFRAC_W'(1);
          end
        end
      end
    end
  end

  // Refractory flags decoded straight from the counter registers
  always_comb begin
    refrac_active = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      refrac_active[i] = (rc_r[i] != '0);
    end
  end

  // Shadow image with this cycle's chunk merged in; it is also the commit source,
  // which gives the same-cycle write bypass. Indices beyond NCHUNK match no chunk.
  always_comb begin
    shadow_next_s = shadow_r;
    chunk_hit_s   = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      chunk_hit_s[k] = in_chunk_we && (in_chunk_idx == IDX_W'(k));
      shadow_next_s[k*CHUNK_W +: CHUNK_W] =
        chunk_hit_s[k] ? in_chunk_data : shadow_r[k*CHUNK_W +: CHUNK_W];
    end
  end

  // Shadow, active spike register and chunk-loaded bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r   <= '0;
      in_spk_out <= '0;
      in_loaded  <= '0;
    end else begin
      shadow_r <= shadow_next_s;
      if (in_commit) begin
        in_spk_out <= shadow_next_s;
        in_loaded  <= chunk_hit_s;
      end else begin
        in_loaded  <= in_loaded | chunk_hit_s;
      end
    end
  end

`ifdef SPK_HIST_EN
  logic [HIST_W-1:0] hist_r [N_NEURONS];

  // Saturating per-neuron spike counts; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || hist_clr) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        hist_r[i] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (fire_s[i] && (hist_r[i] != '1)) begin
          hist_r[i] <= hist_r[i] + HIST_W'(1);
        end
      end
    end
  end

  // History read mux; a select with no matching neuron reads as zero
  always_comb begin
    hist_data = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      hist_data = hist_data | ((hist_sel == SEL_W'(i)) ? hist_r[i] : '0);
    end
  end
`else
  logic hist_unused_s;
  assign hist_unused_s = ^{hist_sel, hist_clr};
  assign hist_data     = {HIST_W{1'b0}};
`endif

endmodule

// File: tb/tb_spk_layer_engine.sv
// Self-checking bench for spk_layer_engine: directed test-plan steps plus randomized
// steps/chunk traffic against a behavioural model. History checks follow SPK_HIST_EN.
module tb_spk_layer_engine;
  localparam int N  = 16;
  localparam int PW = 8;
  localparam int RW = 3;
  localparam int IW = 1024;
  localparam int CW = 128;
  localparam int NC = 8;
  localparam int HW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic signed [PW-1:0] cfg_threshold;
  logic [RW-1:0]        cfg_refrac;
  logic                 step;
  logic [N*PW-1:0]      potential_in;
  logic [N-1:0]         spk_out;
  logic                 spk_valid;
  logic [4:0]           spk_cnt;
  logic [N-1:0]         refrac_active;
  logic [CW-1:0]        in_chunk_data;
  logic [2:0]           in_chunk_idx;
  logic                 in_chunk_we;
  logic                 in_commit;
  logic [IW-1:0]        in_spk_out;
  logic [NC-1:0]        in_loaded;
  logic [3:0]           hist_sel;
  logic                 hist_clr;
  logic [HW-1:0]        hist_data;

  // small instance with 3 chunks so that index 3 is out of range
  logic [7:0]    s_chunk_data;
  logic [1:0]    s_chunk_idx;
  logic          s_chunk_we;
  logic          s_commit;
  logic [23:0]   s_spk_out;
  logic [2:0]    s_loaded;
  logic [N-1:0]  s_unused_spk;
  logic          s_unused_valid;
  logic [4:0]    s_unused_cnt;
  logic [N-1:0]  s_unused_refrac;
  logic [HW-1:0] s_unused_hist;

  spk_layer_engine #(.HIST_W(HW)) dut (
    .clk(clk), .reset(reset), .cfg_threshold(cfg_threshold), .cfg_refrac(cfg_refrac),
    .step(step), .potential_in(potential_in), .spk_out(spk_out), .spk_valid(spk_valid),
    .spk_cnt(spk_cnt), .refrac_active(refrac_active), .in_chunk_data(in_chunk_data),
    .in_chunk_idx(in_chunk_idx), .in_chunk_we(in_chunk_we), .in_commit(in_commit),
    .in_spk_out(in_spk_out), .in_loaded(in_loaded), .hist_sel(hist_sel),
    .hist_clr(hist_clr), .hist_data(hist_data)
  );

  spk_layer_engine #(.IN_SPK_W(24), .CHUNK_W(8), .HIST_W(HW)) dut_small (
    .clk(clk), .reset(reset), .cfg_threshold(cfg_threshold), .cfg_refrac(cfg_refrac),
    .step(step), .potential_in(potential_in), .spk_out(s_unused_spk),
    .spk_valid(s_unused_valid), .spk_cnt(s_unused_cnt), .refrac_active(s_unused_refrac),
    .in_chunk_data(s_chunk_data), .in_chunk_idx(s_chunk_idx), .in_chunk_we(s_chunk_we),
    .in_commit(s_commit), .in_spk_out(s_spk_out), .in_loaded(s_loaded),
    .hist_sel(hist_sel), .hist_clr(hist_clr), .hist_data(s_unused_hist)
  );

  int n_pass  = 0;
  int n_total = 0;

  // behavioural model state
  int          pot_m [N];
  int          rc_m  [N];
  int          hist_m[N];
  logic [N-1:0] spk_m;
  int          cnt_m;
  logic        valid_m;
  logic [CW-1:0] shadow_m[NC];
  logic [CW-1:0] active_m[NC];
  logic [NC-1:0] loaded_m;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_update();
    int hmax;
    hmax = (1 << HW) - 1;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        rc_m[i] = 0; hist_m[i] = 0;
      end
      for (int k = 0; k < NC; k++) begin
        shadow_m[k] = '0; active_m[k] = '0;
      end
      spk_m = '0; cnt_m = 0; valid_m = 1'b0; loaded_m = '0;
    end else begin
      valid_m = step;
      if (step) begin
        spk_m = '0; cnt_m = 0;
        for (int i = 0; i < N; i++) begin
          if (rc_m[i] == 0 && pot_m[i] >= int'(cfg_threshold)) begin
            spk_m[i] = 1'b1;
            cnt_m++;
            rc_m[i] = int'(cfg_refrac);
            if (!hist_clr && hist_m[i] < hmax) hist_m[i]++;
          end else if (rc_m[i] > 0) begin
            rc_m[i]--;
          end
        end
      end
      if (hist_clr) begin
        for (int i = 0; i < N; i++) hist_m[i] = 0;
      end
      if (in_chunk_we) shadow_m[in_chunk_idx] = in_chunk_data;
      if (in_commit) begin
        for (int k = 0; k < NC; k++) active_m[k] = shadow_m[k];
        loaded_m = '0;
      end
      if (in_chunk_we) loaded_m[in_chunk_idx] = 1'b1;
    end
  endtask

  task automatic tick();
    for (int i = 0; i < N; i++) potential_in[i*PW +: PW] = PW'(pot_m[i]);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] ra;
    ra = '0;
    for (int i = 0; i < N; i++) ra[i] = (rc_m[i] != 0);
    check({tag, "_spk"},    128'(spk_out),       128'(spk_m));
    check({tag, "_valid"},  128'(spk_valid),     128'(valid_m));
    check({tag, "_cnt"},    128'(spk_cnt),       128'(cnt_m));
    check({tag, "_refrac"}, 128'(refrac_active), 128'(ra));
    check({tag, "_loaded"}, 128'(in_loaded),     128'(loaded_m));
    for (int k = 0; k < NC; k++)
      check($sformatf("%s_chunk%0d", tag, k), in_spk_out[k*CW +: CW], active_m[k]);
`ifdef SPK_HIST_EN
    check({tag, "_hist"}, 128'(hist_data), 128'(hist_m[hist_sel]));
`else
    check({tag, "_hist"}, 128'(hist_data), 128'(0));
`endif
  endtask

  initial begin
    int t;
    int exp0[3];
    exp0 = '{0, 0, 1};
    reset = 1'b1; step = 1'b0; cfg_threshold = '0; cfg_refrac = '0;
    in_chunk_data = '0; in_chunk_idx = '0; in_chunk_we = 1'b0; in_commit = 1'b0;
    hist_sel = 4'd3; hist_clr = 1'b0;
    s_chunk_data = '0; s_chunk_idx = '0; s_chunk_we = 1'b0; s_commit = 1'b0;
    for (int i = 0; i < N; i++) pot_m[i] = 0;
    tick(); tick();
    check_all("reset");

    // threshold 10, refractory 2: only neuron 0 reaches threshold
    reset = 1'b0; cfg_threshold = 8'sd10; cfg_refrac = 3'd2; step = 1'b1;
    pot_m[0] = 10;
    for (int i = 1; i < N; i++) pot_m[i] = 9;
    tick();
    check_all("first_step");
    check("first_spk", 128'(spk_out), 128'(16'h0001));
    check("first_cnt", 128'(spk_cnt), 128'(5'd1));
    check("first_ra0", 128'(refrac_active[0]), 128'(1'b1));
    for (int j = 0; j < 3; j++) begin
      tick();
      check_all($sformatf("b2b%0d", j));
      check($sformatf("b2b_spk0_%0d", j), 128'(spk_out[0]), 128'(exp0[j]));
      if (j == 1) check("ra0_cleared", 128'(refrac_active[0]), 128'(1'b0));
    end
    step = 1'b0;
    tick();
    check_all("idle_hold");
    check("idle_spk", 128'(spk_out), 128'(16'h0001));

    // negative threshold, equality and large positive potential, no refractory
    reset = 1'b1; tick(); reset = 1'b0;
    cfg_threshold = -8'sd4; cfg_refrac = 3'd0; step = 1'b1;
    pot_m[0] = -4; pot_m[1] = -5; pot_m[2] = 127;
    for (int i = 3; i < N; i++) pot_m[i] = -100;
    for (int j = 0; j < 3; j++) begin
      tick();
      check_all($sformatf("neg%0d", j));
      check($sformatf("neg_spk%0d", j), 128'(spk_out[2:0]), 128'(3'b101));
    end
    step = 1'b0;

    // load every chunk, then commit
    in_chunk_we = 1'b1;
    for (int k = 0; k < NC; k++) begin
      in_chunk_idx = 3'(k); in_chunk_data = CW'(k);
      tick();
      check_all($sformatf("load%0d", k));
    end
    in_chunk_we = 1'b0;
    check("loaded_full", 128'(in_loaded), 128'(8'hFF));
    in_commit = 1'b1;
    tick();
    in_commit = 1'b0;
    check_all("commit");
    check("commit_loaded", 128'(in_loaded), 128'(8'h00));
    for (int k = 0; k < NC; k++)
      check($sformatf("commit_chunk%0d", k), in_spk_out[k*CW +: CW], 128'(k));
    // same-cycle write + commit uses the new chunk
    in_chunk_we = 1'b1; in_chunk_idx = 3'd3; in_chunk_data = {4{32'hDEADBEEF}}; in_commit = 1'b1;
    tick();
    in_chunk_we = 1'b0;
    check_all("bypass");
    check("bypass_chunk3", in_spk_out[3*CW +: CW], {4{32'hDEADBEEF}});
    check("bypass_loaded", 128'(in_loaded), 128'(8'h08));
    tick();
    in_commit = 1'b0;
    check_all("recommit");

    // history: neuron 3 fires on 5 steps, then clear alongside a step
    reset = 1'b1; tick(); reset = 1'b0;
    cfg_threshold = 8'sd0; cfg_refrac = 3'd0; step = 1'b1; hist_sel = 4'd3;
    for (int i = 0; i < N; i++) pot_m[i] = -50;
    pot_m[3] = 50;
    for (int j = 0; j < 5; j++) tick();
    check_all("hist_sat");
`ifdef SPK_HIST_EN
    check("hist_sat_val", 128'(hist_data), 128'(2'd3));
`endif
    hist_clr = 1'b1;
    tick();
    hist_clr = 1'b0;
    check_all("hist_clr");
    check("hist_clr_val", 128'(hist_data), 128'(0));

    // randomized steps and chunk traffic
    for (int j = 0; j < 40; j++) begin
      step = ($urandom_range(0, 3) != 0);
      t = int'($urandom_range(0, 40)) - 20;
      cfg_threshold = PW'(t);
      cfg_refrac = RW'($urandom);
      for (int i = 0; i < N; i++) pot_m[i] = int'($urandom_range(0, 60)) - 30;
      in_chunk_we = $urandom_range(0, 1) != 0;
      in_chunk_idx = 3'($urandom_range(0, 7));
      in_chunk_data = {$urandom, $urandom, $urandom, $urandom};
      in_commit = ($urandom_range(0, 3) == 0);
      hist_clr = ($urandom_range(0, 15) == 0);
      hist_sel = 4'($urandom);
      tick();
      check_all($sformatf("rnd%0d", j));
    end
    in_chunk_we = 1'b0; in_commit = 1'b0; hist_clr = 1'b0;

    // reset during a refractory period clears everything
    cfg_threshold = -8'sd128; cfg_refrac = 3'd5; step = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_all("midreset");
    check("midreset_ra", 128'(refrac_active), 128'(0));
    check("midreset_loaded", 128'(in_loaded), 128'(0));
    reset = 1'b0; step = 1'b0;

    // out-of-range chunk index on the 3-chunk instance
    s_chunk_we = 1'b1; s_chunk_idx = 2'd3; s_chunk_data = 8'hA5;
    tick();
    check("oor_loaded", 128'(s_loaded), 128'(3'b000));
    s_chunk_idx = 2'd1; s_chunk_data = 8'h3C; s_commit = 1'b1;
    tick();
    check("small_commit", 128'(s_spk_out), 128'(24'h003C00));
    check("small_loaded", 128'(s_loaded), 128'(3'b010));
    s_chunk_idx = 2'd3; s_chunk_data = 8'hFF;
    tick();
    check("oor_commit", 128'(s_spk_out), 128'(24'h003C00));
    check("oor_commit_loaded", 128'(s_loaded), 128'(3'b000));
    s_chunk_we = 1'b0; s_commit = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spk_layer_engine.md
Name: spk_layer_engine

Overview:
- Parametrised next-generation spike processor for the SNN accelerator.
- Per-neuron threshold firing with a programmable refractory counter, generalising the single-bit spikeability flag to a multi-step refractory period.
- Double-buffered, chunk-loaded input spike register: the next timestep's input spikes load while the current ones are consumed.
- Sits between the neuron potential accumulators and the layer sequencer.

Parameters:
- N_NEURONS, 16: neurons processed per step.
- POT_W, 8: potential width, signed two's complement.
- REFRAC_W, 3: refractory counter width.
- IN_SPK_W, 1024: input spike register width.
- CHUNK_W, 128: load chunk width. IN_SPK_W must be a multiple of CHUNK_W; NCHUNK = IN_SPK_W/CHUNK_W.
- HIST_W, 8: spike-history counter width (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cfg_threshold  in  POT_W  signed firing threshold
- cfg_refrac  in  REFRAC_W  refractory steps after a spike; 0 = none
- step  in  1  timestep strobe
- potential_in  in  N_NEURONS*POT_W  neuron i at [i*POT_W +: POT_W]
- spk_out  out  N_NEURONS  spikes of last step
- spk_valid  out  1  one-cycle pulse after each step
- spk_cnt  out  $clog2(N_NEURONS+1)  popcount of spk_out
- refrac_active  out  N_NEURONS  1 = neuron cannot fire
- in_chunk_data  in  CHUNK_W  chunk write data
- in_chunk_idx  in  $clog2(NCHUNK) (min 1)  chunk index
- in_chunk_we  in  1  chunk write enable
- in_commit  in  1  copy shadow register to active
- in_spk_out  out  IN_SPK_W  active input spikes
- in_loaded  out  NCHUNK  chunks written since last commit
- hist_sel  in  $clog2(N_NEURONS)  history select (optional feature)
- hist_clr  in  1  clear all history (optional feature)
- hist_data  out  HIST_W  selected history count (optional feature)

Behaviour:
- Reset values: spk_out, spk_valid, spk_cnt, in_spk_out, in_loaded, shadow register, all refractory counters, all history counters = 0.
- Step, on posedge with step=1, per neuron i:
  - fire_i = (rc_i == 0) && ($signed(pot_i) >= $signed(cfg_threshold)).
  - spk_out[i] <= fire_i.
  - rc_i <= fire_i ? cfg_refrac : (rc_i != 0 ? rc_i-1 : 0).
  - spk_valid <= 1; spk_cnt <= popcount(fire).
- Latency 1 cycle. Without step: spk_valid <= 0; spk_out, spk_cnt and counters hold.
- Back-to-back steps are legal: spk_valid stays high, one step is processed per cycle.
- refrac_active[i] = (rc_i != 0), decoded from registers.
- Comparison is signed. Threshold equal to potential fires. Negative potentials never fire for a non-negative threshold.
- cfg_refrac is sampled at the firing step. Changes do not affect counters already running.
- Chunk write, in_chunk_we=1: shadow[idx*CHUNK_W +: CHUNK_W] <= in_chunk_data; in_loaded[idx] <= 1. idx >= NCHUNK is ignored entirely.
- Commit, in_commit=1: in_spk_out <= shadow, including any chunk written in the same cycle (write bypass); in_loaded <= 0, then set only for that same-cycle chunk. Shadow is retained, not cleared.
- Commit with in_loaded=0 recommits the unchanged shadow.
- Reset mid-operation aborts everything: all state returns to reset values next cycle.

Optional Feature:
- Macro SPK_HIST_EN.
- Defined: one HIST_W saturating counter per neuron; +1 at each step where the neuron fires; stays at max once saturated. hist_clr zeroes all counters and has priority over a same-cycle increment. hist_data = count[hist_sel], combinational; hist_sel out of range returns 0.
- Undefined: hist_sel and hist_clr are ignored, hist_data is tied to 0, no counters are built.

Test Plan:
- Reset, then N=16, thr=10, refrac=2; potential 10 on neuron 0, 9 on the rest; step -> next cycle spk_out=0x0001, spk_cnt=1, spk_valid=1, refrac_active[0]=1.
- Hold the same potentials and step 3 more times -> spk_out[0] = 0, 0, 1; refrac_active[0] clears before the third step.
- thr=-4, potentials -4 / -5 / 127 on neurons 0/1/2 -> spk_out[2:0]=3'b101; refrac=0 -> those neurons fire on every step.
- Write chunks 0..7 with pattern k in chunk k, then commit -> in_spk_out chunk k = k, in_loaded 0xFF -> 0x00. Write chunk 3 plus commit in the same cycle -> new chunk 3 visible, in_loaded=0x08.
- Chunk write with out-of-range idx (idx width wider than NCHUNK) -> no change. Assert reset during a refractory period -> all outputs 0 next cycle.
- SPK_HIST_EN: HIST_W=2, 5 firing steps on neuron 3 -> hist_data=3 (saturated); hist_clr together with a step -> 0.
